// File: rtl/priority_resolver.sv
// priority_resolver: 8259-style priority resolver with in-service register and INTA vector sequencing.
// Define ROTATE_PRIORITY_EN to add the rotating lowest-priority register and the rotateOnEoi input.
module priority_resolver (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] risedBits,
    input  logic       readPriorityAck,
    input  logic       INTA_n,
    input  logic [7:0] ICW2,
    input  logic       autoEOI,
    input  logic       eoiStrobe,
    input  logic       specificEoi,
    input  logic [2:0] eoiLevel,
`ifdef ROTATE_PRIORITY_EN
    input  logic       rotateOnEoi,
`endif
    output logic       readPriority,
    output logic [2:0] resetIRR,
    output logic       resetIRRValid,
    output logic       INT,
    output logic [7:0] ISR,
    output logic [7:0] dataBuffer,
    output logic       vectorValid
);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StEval,
        StWaitInta1,
        StWaitInta2,
        StDrive
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] captured_q, captured_d;
    logic [2:0] winner_q, winner_d;
    logic       inta_q;
    logic [7:0] isr_q, isr_d;
    logic       int_q, int_d;
    logic [2:0] reset_irr_q, reset_irr_d;
    logic       reset_irr_valid_q, reset_irr_valid_d;
    logic [7:0] data_q, data_d;
    logic       vector_valid_q, vector_valid_d;

    logic [2:0] lowest;
    logic       inta_fall, inta_rise;
    logic [3:0] req_rank, isr_rank;
    logic [2:0] req_level, isr_top;
    logic       win_ok;
    logic [7:0] isr_set, aeoi_clr, eoi_clr;
    logic       eoi_hit;
    logic [2:0] eoi_level_sel;
    logic       unused_icw2;

    assign unused_icw2 = ^ICW2[2:0];

    // Rotate so the highest-priority level (lowest + 1) lands on bit 0.
    function automatic logic [7:0] rotate_down(logic [7:0] v, logic [2:0] low);
        logic [15:0] dbl;
        logic [2:0]  s;
        s   = low + 3'd1;
        dbl = {v, v} >> s;
        return dbl[7:0];
    endfunction

    // Returns {found, index of lowest set bit}.
    function automatic logic [3:0] first_set(logic [7:0] v);
        logic [3:0] r;
        r = 4'b0000;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) r = {1'b1, 3'(i)};
        end
        return r;
    endfunction

`ifdef ROTATE_PRIORITY_EN
    logic [2:0] lowest_q, lowest_d;
    assign lowest = lowest_q;
`else
    assign lowest = 3'd7;
`endif

    assign inta_fall = inta_q & ~INTA_n;
    assign inta_rise = ~inta_q & INTA_n;

    assign req_rank  = first_set(rotate_down(captured_q, lowest));
    assign isr_rank  = first_set(rotate_down(isr_q, lowest));
    assign req_level = req_rank[2:0] + lowest + 3'd1;
    assign isr_top   = isr_rank[2:0] + lowest + 3'd1;
    // Smaller rank means higher priority; an empty ISR blocks nothing.
    assign win_ok    = req_rank[3] & (~isr_rank[3] | (req_rank[2:0] < isr_rank[2:0]));

    always_comb begin
        state_d           = state_q;
        captured_d        = captured_q;
        winner_d          = winner_q;
        int_d             = int_q;
        reset_irr_d       = reset_irr_q;
        reset_irr_valid_d = 1'b0;
        data_d            = data_q;
        vector_valid_d    = vector_valid_q;
        isr_set           = 8'h00;
        aeoi_clr          = 8'h00;

        unique case (state_q)
            StIdle: state_d = StReq;
            StReq: begin
                if (readPriorityAck) begin
                    captured_d = risedBits;
                    state_d    = StEval;
                end
            end
            StEval: begin
                if (win_ok) begin
                    winner_d = req_level;
                    int_d    = 1'b1;
                    state_d  = StWaitInta1;
                end else begin
                    state_d = StIdle;
                end
            end
            StWaitInta1: begin
                if (inta_fall) begin
                    isr_set           = 8'h01 << winner_q;
                    reset_irr_d       = winner_q;
                    reset_irr_valid_d = 1'b1;
                    int_d             = 1'b0;
                    state_d           = StWaitInta2;
                end
            end
            StWaitInta2: begin
                if (inta_fall) begin
                    data_d         = {ICW2[7:3], winner_q};
                    vector_valid_d = 1'b1;
                    state_d        = StDrive;
                end
            end
            StDrive: begin
                if (inta_rise) begin
                    data_d         = 8'h00;
                    vector_valid_d = 1'b0;
                    if (autoEOI) aeoi_clr = 8'h01 << winner_q;
                    state_d        = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // EOI looks at the pre-update ISR; a same-cycle set of the same bit survives.
    always_comb begin
        eoi_hit       = 1'b0;
        eoi_level_sel = 3'd0;
        eoi_clr       = 8'h00;
        if (eoiStrobe) begin
            if (specificEoi) begin
                eoi_hit       = 1'b1;
                eoi_level_sel = eoiLevel;
            end else if (isr_rank[3]) begin
                eoi_hit       = 1'b1;
                eoi_level_sel = isr_top;
            end
        end
        if (eoi_hit) eoi_clr = 8'h01 << eoi_level_sel;
        isr_d = (isr_q & ~eoi_clr & ~aeoi_clr) | isr_set;
    end

`ifdef ROTATE_PRIORITY_EN
    always_comb begin
        lowest_d = lowest_q;
        if (eoi_hit && rotateOnEoi) lowest_d = eoi_level_sel;
        if ((aeoi_clr != 8'h00) && rotateOnEoi) lowest_d = winner_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lowest_q <= 3'd7;
        end else begin
            lowest_q <= lowest_d;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q           <= StIdle;
            captured_q        <= 8'h00;
            winner_q          <= 3'd0;
            inta_q            <= 1'b1;
            isr_q             <= 8'h00;
            int_q             <= 1'b0;
            reset_irr_q       <= 3'd0;
            reset_irr_valid_q <= 1'b0;
            data_q            <= 8'h00;
            vector_valid_q    <= 1'b0;
        end else begin
            state_q           <= state_d;
            captured_q        <= captured_d;
            winner_q          <= winner_d;
            inta_q            <= INTA_n;
            isr_q             <= isr_d;
            int_q             <= int_d;
            reset_irr_q       <= reset_irr_d;
            reset_irr_valid_q <= reset_irr_valid_d;
            data_q            <= data_d;
            vector_valid_q    <= vector_valid_d;
        end
    end

    assign readPriority  = (state_q == StReq);
    assign resetIRR      = reset_irr_q;
    assign resetIRRValid = reset_irr_valid_q;
    assign INT           = int_q;
    assign ISR           = isr_q;
    assign dataBuffer    = data_q;
    assign vectorValid   = vector_valid_q;

endmodule

// File: tb/tb_priority_resolver.sv
// tb_priority_resolver: directed bench for priority_resolver with a cycle model checked every cycle.
// Also builds with ROTATE_PRIORITY_EN defined, exercising the rotating-priority path.
module tb_priority_resolver;

    logic       clk;
    logic       reset;
    logic [7:0] risedBits;
    logic       readPriorityAck;
    logic       INTA_n;
    logic [7:0] ICW2;
    logic       autoEOI;
    logic       eoiStrobe;
    logic       specificEoi;
    logic [2:0] eoiLevel;
    logic       rotateOnEoi;
    logic       readPriority;
    logic [2:0] resetIRR;
    logic       resetIRRValid;
    logic       INT;
    logic [7:0] ISR;
    logic [7:0] dataBuffer;
    logic       vectorValid;

    int n_total = 0;
    int n_pass  = 0;
    bit cmp_en  = 0;

    priority_resolver dut (
        .clk             (clk),
        .reset           (reset),
        .risedBits       (risedBits),
        .readPriorityAck (readPriorityAck),
        .INTA_n          (INTA_n),
        .ICW2            (ICW2),
        .autoEOI         (autoEOI),
        .eoiStrobe       (eoiStrobe),
        .specificEoi     (specificEoi),
        .eoiLevel        (eoiLevel),
`ifdef ROTATE_PRIORITY_EN
        .rotateOnEoi     (rotateOnEoi),
`endif
        .readPriority    (readPriority),
        .resetIRR        (resetIRR),
        .resetIRRValid   (resetIRRValid),
        .INT             (INT),
        .ISR             (ISR),
        .dataBuffer      (dataBuffer),
        .vectorValid     (vectorValid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    int         m_phase;   // 0 idle,1 asking IRR,2 evaluate,3 await INTA1,4 await INTA2,5 driving
    logic [7:0] m_isr, m_cap, m_db;
    logic       m_int, m_rv, m_vv, m_prev;
    int         m_rirr, m_win, m_low;

    // Walk levels from highest priority (low+1) to lowest (low).
    function automatic int top_level(logic [7:0] v, int low);
        for (int k = 1; k <= 8; k++) begin
            if (v[(low + k) % 8]) return (low + k) % 8;
        end
        return -1;
    endfunction

    function automatic int rank_of(int n, int low);
        return (n + 7 - low) % 8;
    endfunction

    always @(posedge clk or posedge reset) begin : model
        logic [7:0] clr, set;
        int         lvl, w, h, new_low;
        bit         fall, rise, rot;
        if (reset) begin
            m_phase = 0; m_isr = 8'h00; m_cap = 8'h00; m_db = 8'h00;
            m_int = 0; m_rv = 0; m_vv = 0; m_prev = 1;
            m_rirr = 0; m_win = 0; m_low = 7;
        end else begin
`ifdef ROTATE_PRIORITY_EN
            rot = rotateOnEoi;
`else
            rot = 0;
`endif
            fall = m_prev && !INTA_n;
            rise = !m_prev && INTA_n;
            clr = 8'h00;
            set = 8'h00;
            m_rv = 0;
            new_low = m_low;
            if (eoiStrobe) begin
                lvl = specificEoi ? int'(eoiLevel) : top_level(m_isr, m_low);
                if (lvl >= 0) begin
                    clr[lvl] = 1'b1;
                    if (rot) new_low = lvl;
                end
            end
            case (m_phase)
                0: m_phase = 1;
                1: if (readPriorityAck) begin m_cap = risedBits; m_phase = 2; end
                2: begin
                    w = top_level(m_cap, m_low);
                    h = top_level(m_isr, m_low);
                    if (w >= 0 && (h < 0 || rank_of(w, m_low) < rank_of(h, m_low))) begin
                        m_win = w; m_int = 1; m_phase = 3;
                    end else begin
                        m_phase = 0;
                    end
                end
                3: if (fall) begin
                    set[m_win] = 1'b1; m_rirr = m_win; m_rv = 1; m_int = 0; m_phase = 4;
                end
                4: if (fall) begin
                    m_db = {ICW2[7:3], 3'(m_win)}; m_vv = 1; m_phase = 5;
                end
                5: if (rise) begin
                    m_vv = 0; m_db = 8'h00;
                    if (autoEOI) begin
                        clr[m_win] = 1'b1;
                        if (rot) new_low = m_win;
                    end
                    m_phase = 0;
                end
                default: m_phase = 0;
            endcase
            m_isr  = (m_isr & ~clr) | set;
            m_low  = new_low;
            m_prev = INTA_n;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cycle", {readPriority, INT, ISR, resetIRRValid,
                            (resetIRRValid ? resetIRR : 3'd0), dataBuffer, vectorValid},
                           {(m_phase == 1), m_int, m_isr, m_rv,
                            (m_rv ? 3'(m_rirr) : 3'd0), m_db, m_vv});
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_rp();
        int n = 0;
        while (!readPriority && n < 20) begin tick(); n++; end
        check("readPriority_seen", readPriority, 1);
    endtask

    task automatic wait_int();
        int n = 0;
        while (!INT && n < 20) begin tick(); n++; end
        check("int_seen", INT, 1);
    endtask

    task automatic request(input logic [7:0] rb, input int ack_delay);
        wait_rp();
        risedBits = rb;
        repeat (ack_delay) tick();
        readPriorityAck = 1'b1;
        tick();
        readPriorityAck = 1'b0;
    endtask

    task automatic inta(input logic v);
        INTA_n = v;
        tick();
    endtask

    task automatic eoi(input logic spec, input logic [2:0] lvl);
        eoiStrobe = 1'b1; specificEoi = spec; eoiLevel = lvl;
        tick();
        eoiStrobe = 1'b0; specificEoi = 1'b0;
    endtask

    task automatic service(input logic [7:0] rb);
        request(rb, 0);
        wait_int();
        inta(1'b0); inta(1'b1); inta(1'b0); inta(1'b1);
    endtask

    initial begin
        reset = 1'b1; risedBits = 8'h00; readPriorityAck = 1'b0; INTA_n = 1'b1;
        ICW2 = 8'h40; autoEOI = 1'b0; eoiStrobe = 1'b0; specificEoi = 1'b0;
        eoiLevel = 3'd0; rotateOnEoi = 1'b0;
        tick(); tick();
        check("reset_outputs", {readPriority, INT, ISR, resetIRRValid, dataBuffer, vectorValid}, 0);
        reset = 1'b0;
        cmp_en = 1'b1;

        // IR3 and IR5 pending, IR3 wins; ack two cycles after readPriority.
        request(8'h28, 2);
        wait_int();
        inta(1'b0);
        check("inta1_strobe", resetIRRValid, 1);
        check("inta1_level", resetIRR, 3);
        check("inta1_isr", ISR, 8'h08);
        check("inta1_int_low", INT, 0);
        inta(1'b1);
        check("strobe_one_cycle", resetIRRValid, 0);
        inta(1'b0);
        check("inta2_valid", vectorValid, 1);
        check("inta2_vector", dataBuffer, 8'h43);
        inta(1'b1);
        check("drive_end_valid", vectorValid, 0);
        check("drive_end_data", dataBuffer, 8'h00);

        // ISR=04 blocks IR4, but IR0 outranks it.
        eoi(1'b1, 3'd3);
        check("specific_eoi3", ISR, 8'h00);
        service(8'h04);
        check("isr_ir2", ISR, 8'h04);
        request(8'h10, 0);
        tick(); tick();
        check("ir4_blocked", INT, 0);
        wait_rp();
        readPriorityAck = 1'b1; risedBits = 8'h01;
        tick();
        readPriorityAck = 1'b0;
        wait_int();
        inta(1'b0); inta(1'b1); inta(1'b0); inta(1'b1);
        check("isr_ir0_ir2", ISR, 8'h05);
        eoi(1'b0, 3'd0);
        check("nonspecific_clears_ir0", ISR, 8'h04);
        eoi(1'b1, 3'd2);

        // Auto-EOI: IR5 clears on the closing INTA rising edge.
        autoEOI = 1'b1;
        request(8'h20, 0);
        wait_int();
        inta(1'b0);
        check("aeoi_set", ISR, 8'h20);
        inta(1'b1); inta(1'b0);
        check("aeoi_held", ISR, 8'h20);
        inta(1'b1);
        check("aeoi_cleared", ISR, 8'h00);
        autoEOI = 1'b0;

        // ISR=24: non-specific EOI drops IR2, specific EOI 5 drops IR5.
        service(8'h20);
        service(8'h04);
        check("isr_24", ISR, 8'h24);
        eoi(1'b0, 3'd0);
        check("nonspecific_eoi", ISR, 8'h20);
        eoi(1'b1, 3'd5);
        check("specific_eoi5", ISR, 8'h00);

        // EOI on the same cycle as the INTA1 set acts on the old ISR.
        service(8'h20);
        request(8'h04, 0);
        wait_int();
        eoiStrobe = 1'b1; specificEoi = 1'b0;
        inta(1'b0);
        eoiStrobe = 1'b0;
        check("eoi_same_cycle", ISR, 8'h04);
        inta(1'b1); inta(1'b0); inta(1'b1);
        eoi(1'b1, 3'd2);

        // Reset between INTA1 and INTA2.
        request(8'h02, 0);
        wait_int();
        inta(1'b0); inta(1'b1);
        #2 reset = 1'b1;
        #1;
        check("async_reset_outputs",
              {readPriority, INT, ISR, resetIRRValid, resetIRR, dataBuffer, vectorValid}, 0);
        tick();
        reset = 1'b0;
        inta(1'b0); inta(1'b1); inta(1'b0);
        check("no_vector_after_reset", {vectorValid, dataBuffer}, 0);
        inta(1'b1);

`ifdef ROTATE_PRIORITY_EN
        // Rotating EOI at level 2 makes IR3 highest, so 09 selects IR3.
        rotateOnEoi = 1'b1;
        eoi(1'b1, 3'd2);
        rotateOnEoi = 1'b0;
        request(8'h09, 0);
        wait_int();
        inta(1'b0);
        check("rot_isr", ISR, 8'h08);
        inta(1'b1); inta(1'b0);
        check("rot_vector", dataBuffer, 8'h43);
        inta(1'b1);
`else
        // Fixed priority: 09 selects IR0.
        request(8'h09, 0);
        wait_int();
        inta(1'b0);
        check("fixed_isr", ISR, 8'h01);
        inta(1'b1); inta(1'b0);
        check("fixed_vector", dataBuffer, 8'h40);
        inta(1'b1);
`endif
        tick(); tick();
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
